// File: rtl/decomp_row_sequencer.sv
// rtl/decomp_row_sequencer.sv - row sequencer between IO buffers and the run-length row decompressor
//
// Ports:
//   clk, rst           clock (posedge) and asynchronous active-low reset
//   start, abort       job launch (sampled in IDLE) and job cancel
//   src_base, dst_base first source / destination row address, latched on start
//   row_count          rows in the job, latched on start
//   busy, done, err    status: not-IDLE, end-of-job pulse, sticky timeout flag
//   rows_done          rows written in the current/last job
//   rd_en, rd_addr     source read port; rd_data returns one cycle after rd_en
//   dec_data, dec_enable, dec_rst   decompressor input row, trigger, active-low clear
//   dec_done, dec_result            decompressor completion level and output row
//   wr_en, wr_addr, wr_data         destination write port
module decomp_row_sequencer #(
    parameter int ROW_SIZE = 16,
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    input  logic [CNT_W-1:0]    row_count,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    rows_done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [ROW_SIZE-1:0] rd_data,
    output logic [ROW_SIZE-1:0] dec_data,
    output logic                dec_enable,
    output logic                dec_rst,
    input  logic                dec_done,
    input  logic [ROW_SIZE-1:0] dec_result,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [ROW_SIZE-1:0] wr_data
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_CLR,
        S_FIRE,
        S_WAIT,
        S_WR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  idx;
    logic [TW-1:0]     tcnt;
    logic [CNT_W-1:0]  idx_next;

    assign idx_next = idx + CNT_W'(1);

    // Outputs are registered: each transition loads the strobe/address values
    // belonging to the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            idx        <= '0;
            tcnt       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rows_done  <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            dec_data   <= '0;
            dec_enable <= 1'b0;
            dec_rst    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && abort) begin
                // Silent cancel: no done pulse, err untouched, an in-flight
                // write is not counted in rows_done.
                state      <= S_IDLE;
                busy       <= 1'b0;
                rd_en      <= 1'b0;
                dec_enable <= 1'b0;
                wr_en      <= 1'b0;
                dec_rst    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        dec_rst <= 1'b1;
                        if (start && !abort) begin
                            src_q     <= src_base;
                            dst_q     <= dst_base;
                            cnt_q     <= row_count;
                            err       <= 1'b0;
                            rows_done <= '0;
                            idx       <= '0;
                            if (row_count == '0) begin
                                done <= 1'b1;
                            end else begin
                                state   <= S_RD;
                                busy    <= 1'b1;
                                rd_en   <= 1'b1;
                                rd_addr <= src_base;
                            end
                        end
                    end
                    S_RD: begin
                        rd_en <= 1'b0;
                        state <= S_CAP;
                    end
                    S_CAP: begin
                        dec_data <= rd_data;
                        // Pull the clear low so a done left over from the
                        // previous row cannot be mistaken for this row's.
                        dec_rst  <= 1'b0;
                        state    <= S_CLR;
                    end
                    S_CLR: begin
                        dec_rst    <= 1'b1;
                        dec_enable <= 1'b1;
                        tcnt       <= '0;
                        state      <= S_FIRE;
                    end
                    S_FIRE: begin
                        dec_enable <= 1'b0;
                        state      <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (dec_done) begin
                            wr_en   <= 1'b1;
                            wr_addr <= dst_q + ADDR_W'(idx);
                            wr_data <= dec_result;
                            state   <= S_WR;
                        end else if (tcnt == TW'(TIMEOUT - 1)) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    S_WR: begin
                        wr_en     <= 1'b0;
                        rows_done <= rows_done + CNT_W'(1);
                        idx       <= idx_next;
                        if (idx_next == cnt_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            rd_en   <= 1'b1;
                            rd_addr <= src_q + ADDR_W'(idx_next);
                            state   <= S_RD;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decomp_row_sequencer.sv
// tb/tb_decomp_row_sequencer.sv - scoreboard bench for decomp_row_sequencer
module tb_decomp_row_sequencer;

    localparam int RS = 16;
    localparam int AW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [CW-1:0] row_count = '0;
    logic          busy, done, err;
    logic [CW-1:0] rows_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [RS-1:0] rd_data = '0;
    logic [RS-1:0] dec_data;
    logic          dec_enable, dec_rst;
    logic          dec_done = 1'b0;
    logic [RS-1:0] dec_result = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [RS-1:0] wr_data;

    always #5 clk = ~clk;

    decomp_row_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_base(src_base), .dst_base(dst_base), .row_count(row_count),
        .busy(busy), .done(done), .err(err), .rows_done(rows_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .dec_data(dec_data), .dec_enable(dec_enable), .dec_rst(dec_rst),
        .dec_done(dec_done), .dec_result(dec_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RS-1:0] expand(input logic [RS-1:0] x);
        return {x[3:0], x[15:4]} ^ 16'hC3A5;
    endfunction

    // Source buffer: registered read, data valid the cycle after rd_en.
    logic [RS-1:0] mem [256];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Decompressor model: result lat cycles after a rising dec_enable
    // (lat=0 means done already in the first WAIT cycle); done holds until dec_rst low.
    int   lat = 2;
    logic hang = 1'b0;
    logic en_q = 1'b0;
    int   dcnt = 0;
    always @(posedge clk) begin
        en_q <= dec_enable;
        if (!rst || !dec_rst) begin
            dec_done <= 1'b0;
            dcnt     <= 0;
        end else if (dec_enable && !en_q && !hang) begin
            if (lat == 0) begin
                dec_done   <= 1'b1;
                dec_result <= expand(dec_data);
            end else begin
                dcnt <= lat;
            end
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                dec_done   <= 1'b1;
                dec_result <= expand(dec_data);
            end
        end
    end

    // Scoreboard queues filled by stimulus, drained by the monitor.
    logic [AW-1:0]    q_rd[$];
    logic [AW+RS-1:0] q_wr[$];
    logic [CW:0]      q_done[$];

    int cyc = 0;
    int busy_cnt = 0;
    int clr_cnt = 0;
    int fire_cyc = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            if (rd_en) begin
                if (q_rd.size() == 0) chk("rd_unexpected", 32'(rd_addr), 32'hFFFF_FFFF);
                else chk("rd_addr", 32'(rd_addr), 32'(q_rd.pop_front()));
            end
            if (wr_en) begin
                if (q_wr.size() == 0) chk("wr_unexpected", 32'({wr_addr, wr_data}), 32'hFFFF_FFFF);
                else chk("wr_addr_data", 32'({wr_addr, wr_data}), 32'(q_wr.pop_front()));
            end
            if (done) begin
                done_cyc = cyc;
                if (q_done.size() == 0) chk("done_unexpected", 32'({err, rows_done}), 32'hFFFF_FFFF);
                else chk("done_err_rows", 32'({err, rows_done}), 32'(q_done.pop_front()));
            end
            if ((rd_en && dec_enable) || (rd_en && wr_en) || (dec_enable && wr_en))
                chk("strobe_exclusive", 32'({rd_en, dec_enable, wr_en}), 32'h0);
            if (busy) busy_cnt++;
            if (busy && !dec_rst) clr_cnt++;
            if (dec_enable) fire_cyc = cyc;
        end
    end

    task automatic push_job(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input int cnt, input int n_rows, input logic exp_err, input logic push_done);
        logic [AW-1:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = src + AW'(i);
            q_rd.push_back(a);
            if (i < n_rows) q_wr.push_back({dst + AW'(i), expand(mem[a])});
        end
        if (push_done) q_done.push_back({exp_err, CW'(n_rows)});
    endtask

    task automatic pulse_start(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                               input logic [CW-1:0] cnt, input logic ab);
        src_base  = src;
        dst_base  = dst;
        row_count = cnt;
        start     = 1'b1;
        abort     = ab;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        if (busy) chk("wait_idle_bound", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h5A, ~8'(i)};

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_flags", 32'({busy, done, err, rd_en, dec_enable, wr_en, dec_rst}), 32'h0);
        chk("reset_rows_addr", 32'({rows_done, rd_addr, wr_addr}), 32'h0);
        chk("reset_data", 32'({dec_data, wr_data}), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_dec_rst", 32'(dec_rst), 32'h1);

        // 1: three rows, done two cycles after trigger
        lat = 2;
        clr_cnt = 0;
        push_job(8'h10, 8'h40, 3, 3, 1'b0, 1'b1);
        pulse_start(8'h10, 8'h40, 8'd3, 1'b0);
        wait_idle();
        chk("t1_rows_done", 32'(rows_done), 32'd3);
        chk("t1_err", 32'(err), 32'h0);
        chk("t1_clr_cycles", 32'(clr_cnt), 32'd3);

        // 2: address wrap FE,FF,00,01 and 6 cycles per row
        lat = 0;
        busy_cnt = 0;
        push_job(8'hFE, 8'hFE, 4, 4, 1'b0, 1'b1);
        pulse_start(8'hFE, 8'hFE, 8'd4, 1'b0);
        wait_idle();
        chk("t2_rows_done", 32'(rows_done), 32'd4);
        chk("t2_busy_cycles", 32'(busy_cnt), 32'd24);

        // 3: decompressor never finishes -> timeout 64 cycles after WAIT entry
        hang = 1'b1;
        push_job(8'h20, 8'h60, 1, 0, 1'b1, 1'b1);
        pulse_start(8'h20, 8'h60, 8'd2, 1'b0);
        wait_idle();
        chk("t3_timeout_latency", 32'(done_cyc - fire_cyc), 32'd65);
        chk("t3_err", 32'(err), 32'h1);
        chk("t3_rows_done", 32'(rows_done), 32'h0);
        hang = 1'b0;

        // 5: zero rows; also clears err from the timeout
        busy_cnt = 0;
        q_done.push_back({1'b0, CW'(0)});
        pulse_start(8'h00, 8'h00, 8'd0, 1'b0);
        wait_idle();
        chk("t5_done_next_cycle", 32'(done_cyc), 32'(start_cyc));
        chk("t5_err_cleared", 32'(err), 32'h0);
        chk("t5_busy_cycles", 32'(busy_cnt), 32'h0);

        // 4: abort during WAIT of row 2 of 5
        lat = 10;
        push_job(8'h30, 8'h80, 2, 1, 1'b0, 1'b0);
        pulse_start(8'h30, 8'h80, 8'd5, 1'b0);
        fires = 0;
        n = 0;
        while (fires < 2 && n < 500) begin
            @(negedge clk);
            n++;
            if (dec_enable) fires++;
        end
        chk("t4_second_fire_seen", 32'(fires), 32'd2);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t4_idle_after_abort", 32'(busy), 32'h0);
        chk("t4_rows_done", 32'(rows_done), 32'd1);
        repeat (30) @(negedge clk);

        // start and abort together: abort wins, nothing launches
        pulse_start(8'h00, 8'h00, 8'd3, 1'b1);
        repeat (5) @(negedge clk);
        chk("start_abort_busy", 32'(busy), 32'h0);
        chk("start_abort_rows_kept", 32'(rows_done), 32'd1);

        // 6: stale done held high from the aborted row
        chk("t6_stale_done_present", 32'(dec_done), 32'h1);
        lat = 3;
        clr_cnt = 0;
        push_job(8'h50, 8'h90, 3, 3, 1'b0, 1'b1);
        pulse_start(8'h50, 8'h90, 8'd3, 1'b0);
        wait_idle();
        chk("t6_clr_cycles", 32'(clr_cnt), 32'd3);
        chk("t6_rows_done", 32'(rows_done), 32'd3);

        chk("left_rd", 32'(q_rd.size()), 32'h0);
        chk("left_wr", 32'(q_wr.size()), 32'h0);
        chk("left_done", 32'(q_done.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
